// File: rtl/mmu_arbiter.sv
// Two-master arbiter sharing the single mmu memory port between the cpu (m0) and a debug engine (m1).
// It registers the granted request onto the mmu port and routes ready/data back, with an optional watchdog.
module mmu_arbiter #(
    parameter bit          ROUND_ROBIN    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_read_enable,
    input  logic        m0_write_enable,
    input  logic        m0_mem_signed_read,
    input  logic [1:0]  m0_mem_data_width,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_data_in,
    output logic [31:0] m0_data_out,
    output logic        m0_mem_ready,
    output logic        m0_bus_error,
    input  logic        m1_read_enable,
    input  logic        m1_write_enable,
    input  logic        m1_mem_signed_read,
    input  logic [1:0]  m1_mem_data_width,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_data_in,
    output logic [31:0] m1_data_out,
    output logic        m1_mem_ready,
    output logic        m1_bus_error,
    output logic        mmu_read_enable,
    output logic        mmu_write_enable,
    output logic        mmu_mem_signed_read,
    output logic [1:0]  mmu_mem_data_width,
    output logic [31:0] mmu_address,
    output logic [31:0] mmu_data_in,
    input  logic [31:0] mmu_data_out,
    input  logic        mmu_mem_ready
);

    localparam int unsigned CW = 32;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic          last_grant;
    logic          grant;
    logic [CW-1:0] count;

    logic          req0;
    logic          req1;
    logic          pick1;
    logic          sel_re;
    logic          sel_we;
    logic          sel_sr;
    logic [1:0]    sel_w;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_din;

    // Master 1 wins when it is alone, or on contention when round-robin says it is its turn
    assign req0  = m0_read_enable | m0_write_enable;
    assign req1  = m1_read_enable | m1_write_enable;
    assign pick1 = req1 & (~req0 | (ROUND_ROBIN & ~last_grant));

    assign sel_re   = pick1 ? m1_read_enable     : m0_read_enable;
    assign sel_we   = pick1 ? m1_write_enable    : m0_write_enable;
    assign sel_sr   = pick1 ? m1_mem_signed_read : m0_mem_signed_read;
    assign sel_w    = pick1 ? m1_mem_data_width  : m0_mem_data_width;
    assign sel_addr = pick1 ? m1_address         : m0_address;
    assign sel_din  = pick1 ? m1_data_in         : m0_data_in;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state               <= IDLE;
            last_grant          <= 1'b1;
            grant               <= 1'b0;
            count               <= '0;
            m0_data_out         <= '0;
            m0_mem_ready        <= 1'b0;
            m0_bus_error        <= 1'b0;
            m1_data_out         <= '0;
            m1_mem_ready        <= 1'b0;
            m1_bus_error        <= 1'b0;
            mmu_read_enable     <= 1'b0;
            mmu_write_enable    <= 1'b0;
            mmu_mem_signed_read <= 1'b0;
            mmu_mem_data_width  <= '0;
            mmu_address         <= '0;
            mmu_data_in         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant               <= pick1;
                        last_grant          <= pick1;
                        mmu_write_enable    <= sel_we;
                        mmu_read_enable     <= sel_re & ~sel_we;
                        mmu_mem_signed_read <= sel_sr;
                        mmu_mem_data_width  <= sel_w;
                        mmu_address         <= sel_addr;
                        mmu_data_in         <= sel_din;
                        count               <= '0;
                        state               <= BUSY;
                    end
                end
                BUSY: begin
                    // A real completion on the watchdog's last cycle takes precedence over the abort
                    if (mmu_mem_ready) begin
                        if (grant) begin
                            m1_data_out  <= mmu_data_out;
                            m1_mem_ready <= 1'b1;
                        end else begin
                            m0_data_out  <= mmu_data_out;
                            m0_mem_ready <= 1'b1;
                        end
                        mmu_read_enable  <= 1'b0;
                        mmu_write_enable <= 1'b0;
                        state            <= RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (count == CW'(TIMEOUT_CYCLES - 1))) begin
                        if (grant) begin
                            m1_data_out  <= ERR_DATA;
                            m1_mem_ready <= 1'b1;
                            m1_bus_error <= 1'b1;
                        end else begin
                            m0_data_out  <= ERR_DATA;
                            m0_mem_ready <= 1'b1;
                            m0_bus_error <= 1'b1;
                        end
                        mmu_read_enable  <= 1'b0;
                        mmu_write_enable <= 1'b0;
                        state            <= RESP;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                RESP: begin
                    m0_mem_ready <= 1'b0;
                    m0_bus_error <= 1'b0;
                    m1_mem_ready <= 1'b0;
                    m1_bus_error <= 1'b0;
                    count        <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed and randomized bench for mmu_arbiter: a round-robin instance with an 8-cycle watchdog,
// plus a fixed-priority instance without a watchdog.
module tb_mmu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        m0_re = 0, m0_we = 0, m0_sr = 0, m1_re = 0, m1_we = 0, m1_sr = 0;
    logic [1:0]  m0_w = 0, m1_w = 0;
    logic [31:0] m0_addr = 0, m0_din = 0, m1_addr = 0, m1_din = 0;
    logic [31:0] m0_dout, m1_dout;
    logic        m0_rdy, m0_err, m1_rdy, m1_err;
    logic        mmu_re, mmu_we, mmu_sr;
    logic [1:0]  mmu_w;
    logic [31:0] mmu_addr, mmu_din;
    logic [31:0] mmu_dout = 0;
    logic        mmu_rdy = 0;

    logic        b_m0_re = 0, b_m1_re = 0;
    logic [31:0] b_m0_addr = 0, b_m1_addr = 0;
    logic [31:0] b_m0_dout, b_m1_dout;
    logic        b_m0_rdy, b_m0_err, b_m1_rdy, b_m1_err;
    logic        b_mmu_re, b_mmu_we, b_mmu_sr;
    logic [1:0]  b_mmu_w;
    logic [31:0] b_mmu_addr, b_mmu_din;
    logic [31:0] b_mmu_dout = 0;
    logic        b_mmu_rdy = 0;
    logic        b_zero = 1'b0;
    logic [1:0]  b_zero2 = 2'b00;
    logic [31:0] b_zero32 = 32'h0;

    mmu_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_read_enable(m0_re), .m0_write_enable(m0_we), .m0_mem_signed_read(m0_sr),
        .m0_mem_data_width(m0_w), .m0_address(m0_addr), .m0_data_in(m0_din),
        .m0_data_out(m0_dout), .m0_mem_ready(m0_rdy), .m0_bus_error(m0_err),
        .m1_read_enable(m1_re), .m1_write_enable(m1_we), .m1_mem_signed_read(m1_sr),
        .m1_mem_data_width(m1_w), .m1_address(m1_addr), .m1_data_in(m1_din),
        .m1_data_out(m1_dout), .m1_mem_ready(m1_rdy), .m1_bus_error(m1_err),
        .mmu_read_enable(mmu_re), .mmu_write_enable(mmu_we), .mmu_mem_signed_read(mmu_sr),
        .mmu_mem_data_width(mmu_w), .mmu_address(mmu_addr), .mmu_data_in(mmu_din),
        .mmu_data_out(mmu_dout), .mmu_mem_ready(mmu_rdy)
    );

    mmu_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(0), .ERR_DATA(32'hDEADBEEF)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_read_enable(b_m0_re), .m0_write_enable(b_zero), .m0_mem_signed_read(b_zero),
        .m0_mem_data_width(b_zero2), .m0_address(b_m0_addr), .m0_data_in(b_zero32),
        .m0_data_out(b_m0_dout), .m0_mem_ready(b_m0_rdy), .m0_bus_error(b_m0_err),
        .m1_read_enable(b_m1_re), .m1_write_enable(b_zero), .m1_mem_signed_read(b_zero),
        .m1_mem_data_width(b_zero2), .m1_address(b_m1_addr), .m1_data_in(b_zero32),
        .m1_data_out(b_m1_dout), .m1_mem_ready(b_m1_rdy), .m1_bus_error(b_m1_err),
        .mmu_read_enable(b_mmu_re), .mmu_write_enable(b_mmu_we), .mmu_mem_signed_read(b_mmu_sr),
        .mmu_mem_data_width(b_mmu_w), .mmu_address(b_mmu_addr), .mmu_data_in(b_mmu_din),
        .mmu_data_out(b_mmu_dout), .mmu_mem_ready(b_mmu_rdy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state for the randomized phase
    bit          pend [2];
    bit          rre [2], rwe [2], rsr [2];
    logic [1:0]  rw [2];
    logic [31:0] raddr [2], rdin [2], lastd [2];
    int          exp_last;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bounded wait until the mmu port shows a request
    task automatic wait_grant(input string tag);
        for (int i = 0; i < 10; i++) begin
            step();
            if (mmu_re || mmu_we) break;
        end
        chk(tag, 32'(mmu_re | mmu_we), 32'd1);
    endtask

    // mmu answers d cycles after the enable first shows; d >= 8 never answers
    task automatic serve(input int d, input logic [31:0] data);
        int c = 0;
        while (c < d && c < 8) begin
            step();
            c++;
        end
        if (d <= 7) begin
            mmu_rdy  = 1'b1;
            mmu_dout = data;
            step();
            mmu_rdy  = 1'b0;
        end
    endtask

    task automatic drive_model();
        m0_re = pend[0] & rre[0]; m0_we = pend[0] & rwe[0]; m0_sr = rsr[0];
        m0_w = rw[0]; m0_addr = raddr[0]; m0_din = rdin[0];
        m1_re = pend[1] & rre[1]; m1_we = pend[1] & rwe[1]; m1_sr = rsr[1];
        m1_w = rw[1]; m1_addr = raddr[1]; m1_din = rdin[1];
    endtask

    task automatic new_req(input int k);
        int op;
        op       = int'($urandom_range(2, 0));
        pend[k]  = 1'b1;
        rre[k]   = (op != 1);
        rwe[k]   = (op != 0);
        rsr[k]   = 1'($urandom_range(1, 0));
        rw[k]    = 2'($urandom_range(3, 0));
        raddr[k] = $urandom;
        rdin[k]  = $urandom;
    endtask

    function automatic logic rdy_of(input int k);
        return (k == 1) ? m1_rdy : m0_rdy;
    endfunction

    function automatic logic err_of(input int k);
        return (k == 1) ? m1_err : m0_err;
    endfunction

    function automatic logic [31:0] dout_of(input int k);
        return (k == 1) ? m1_dout : m0_dout;
    endfunction

    initial begin
        int          win, d, seen;
        logic [31:0] data, expd;
        logic [31:0] rr_exp [4];

        // Reset then idle
        step(); step();
        chk("reset_ctrl", 32'({mmu_re, mmu_we, mmu_sr, mmu_w, m0_rdy, m0_err, m1_rdy, m1_err}), 32'd0);
        chk("reset_mmu_addr", mmu_addr, 32'd0);
        chk("reset_mmu_din", mmu_din, 32'd0);
        chk("reset_m0_dout", m0_dout, 32'd0);
        chk("reset_m1_dout", m1_dout, 32'd0);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mmu_re || mmu_we || m0_rdy || m1_rdy) seen++;
        end
        chk("idle_quiet", 32'(seen), 32'd0);

        // Single read from m0
        m0_re = 1; m0_addr = 32'h10; m0_w = 2'b10;
        step();
        chk("rd_mmu_re", 32'(mmu_re), 32'd1);
        chk("rd_mmu_we", 32'(mmu_we), 32'd0);
        chk("rd_mmu_addr", mmu_addr, 32'h10);
        chk("rd_mmu_w", 32'(mmu_w), 32'd2);
        serve(2, 32'h12345678);
        chk("rd_m0_rdy", 32'(m0_rdy), 32'd1);
        chk("rd_m0_dout", m0_dout, 32'h12345678);
        chk("rd_m1_rdy", 32'(m1_rdy), 32'd0);
        chk("rd_m0_err", 32'(m0_err), 32'd0);
        chk("rd_mmu_off", 32'(mmu_re), 32'd0);
        m0_re = 0;
        step();
        chk("rd_pulse_end", 32'(m0_rdy), 32'd0);

        // Write with read also set; later input changes ignored while busy
        m1_we = 1; m1_re = 1; m1_din = 32'hA5A5A5A5; m1_w = 2'b10; m1_addr = 32'h40;
        wait_grant("wr_grant");
        chk("wr_mmu_we", 32'(mmu_we), 32'd1);
        chk("wr_mmu_re", 32'(mmu_re), 32'd0);
        chk("wr_mmu_din", mmu_din, 32'hA5A5A5A5);
        chk("wr_mmu_addr", mmu_addr, 32'h40);
        m1_addr = 32'h44; m1_din = 32'h0;
        step();
        chk("wr_hold_addr", mmu_addr, 32'h40);
        chk("wr_hold_din", mmu_din, 32'hA5A5A5A5);
        serve(0, 32'h0);
        chk("wr_m1_rdy", 32'(m1_rdy), 32'd1);
        chk("wr_m0_rdy", 32'(m0_rdy), 32'd0);
        chk("wr_m0_hold", m0_dout, 32'h12345678);
        m1_we = 0; m1_re = 0;
        step();

        // Round-robin contention: m0,m1,m0,m1
        rr_exp[0] = 32'h100; rr_exp[1] = 32'h200; rr_exp[2] = 32'h100; rr_exp[3] = 32'h200;
        m0_re = 1; m0_addr = 32'h100; m1_re = 1; m1_addr = 32'h200; m1_we = 0;
        for (int t = 0; t < 4; t++) begin
            wait_grant("rr_grant");
            chk("rr_addr", mmu_addr, rr_exp[t]);
            serve(1, 32'(t));
        end
        m0_re = 0; m1_re = 0;
        step();

        // Watchdog: mmu never answers
        m0_re = 1; m0_addr = 32'h300;
        wait_grant("to_grant");
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (m0_rdy) seen++;
        end
        chk("to_no_early", 32'(seen), 32'd0);
        step();
        chk("to_m0_rdy", 32'(m0_rdy), 32'd1);
        chk("to_m0_err", 32'(m0_err), 32'd1);
        chk("to_m0_dout", m0_dout, 32'hDEADBEEF);
        chk("to_mmu_off", 32'(mmu_re), 32'd0);
        m0_re = 0;
        step();
        chk("to_pulse_end", 32'({m0_rdy, m0_err}), 32'd0);
        step();
        chk("to_idle", 32'(mmu_re), 32'd0);

        // mmu answers on the last watchdog cycle: no error
        m0_re = 1; m0_addr = 32'h304;
        wait_grant("to8_grant");
        serve(7, 32'hCAFE0008);
        chk("to8_rdy", 32'(m0_rdy), 32'd1);
        chk("to8_err", 32'(m0_err), 32'd0);
        chk("to8_dout", m0_dout, 32'hCAFE0008);
        m0_re = 0;
        step();

        // Reset mid-BUSY with m0 granted; m0 must win the next contention
        m0_re = 1; m0_addr = 32'h500;
        wait_grant("rst_grant");
        step();
        reset_n = 1'b0;
        step();
        chk("rst_mmu_off", 32'({mmu_re, mmu_we}), 32'd0);
        chk("rst_no_rdy", 32'({m0_rdy, m1_rdy, m0_err, m1_err}), 32'd0);
        reset_n = 1'b1;
        m1_re = 1; m1_addr = 32'h600;
        wait_grant("rst_regrant");
        chk("rst_m0_wins", mmu_addr, 32'h500);
        serve(0, 32'h55);
        chk("rst_m0_rdy", 32'(m0_rdy), 32'd1);
        m0_re = 0; m1_re = 0;
        step();

        // Randomized phase from a clean reset
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_last = 1;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; lastd[k] = 32'h0; rre[k] = 0; rwe[k] = 0; rsr[k] = 0;
            rw[k] = 0; raddr[k] = 0; rdin[k] = 0;
        end
        drive_model();
        for (int t = 0; t < 150; t++) begin
            for (int k = 0; k < 2; k++)
                if (!pend[k] && $urandom_range(9, 0) < 7) new_req(k);
            if (!pend[0] && !pend[1]) new_req(int'($urandom_range(1, 0)));
            drive_model();
            wait_grant("rnd_grant");
            win = (pend[0] && pend[1]) ? 1 - exp_last : (pend[1] ? 1 : 0);
            exp_last = win;
            chk("rnd_addr", mmu_addr, raddr[win]);
            chk("rnd_we", 32'(mmu_we), 32'(rwe[win]));
            chk("rnd_re", 32'(mmu_re), 32'(rre[win] & ~rwe[win]));
            chk("rnd_side", 32'({mmu_sr, mmu_w}), 32'({rsr[win], rw[win]}));
            chk("rnd_din", mmu_din, rdin[win]);
            d    = int'($urandom_range(9, 0));
            data = $urandom;
            serve(d, data);
            expd = (d <= 7) ? data : 32'hDEADBEEF;
            chk("rnd_rdy", 32'(rdy_of(win)), 32'd1);
            chk("rnd_err", 32'(err_of(win)), 32'(d > 7));
            chk("rnd_dout", dout_of(win), expd);
            chk("rnd_other_rdy", 32'(rdy_of(1 - win)), 32'd0);
            chk("rnd_other_dout", dout_of(1 - win), lastd[1 - win]);
            lastd[win] = expd;
            pend[win]  = 0;
            drive_model();
        end
        for (int k = 0; k < 2; k++) pend[k] = 0;
        drive_model();
        step();

        // Fixed priority instance: m1 starves while m0 keeps requesting
        b_m0_re = 1; b_m0_addr = 32'h700; b_m1_re = 1; b_m1_addr = 32'h800;
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 10; i++) begin
                step();
                if (b_mmu_re) break;
            end
            chk("fp_grant", 32'(b_mmu_re), 32'd1);
            chk("fp_addr", b_mmu_addr, 32'h700);
            seen = 0;
            for (int i = 0; i < ((t == 4) ? 12 : 1); i++) begin
                step();
                if (b_m0_rdy || b_m0_err) seen++;
            end
            chk("fp_no_abort", 32'(seen), 32'd0);
            b_mmu_rdy = 1; b_mmu_dout = 32'hB000_0000 + 32'(t);
            step();
            b_mmu_rdy = 0;
            chk("fp_m0_rdy", 32'(b_m0_rdy), 32'd1);
            chk("fp_m0_dout", b_m0_dout, 32'hB000_0000 + 32'(t));
            chk("fp_m1_rdy", 32'(b_m1_rdy), 32'd0);
        end
        b_m0_re = 0; b_m1_re = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmu_arbiter.md
Name: mmu_arbiter

Overview:
- Two-master arbiter that shares the single mmu memory port between the cpu (master 0) and a debug/dump engine (master 1), for example a UART memory dumper.
- Sits between the requesters and mmu in soc.
- Serialises transactions, registers the selected request onto the mmu port, and routes mem_ready and read data back to the granted master.
- Provides round-robin or fixed priority arbitration and an optional watchdog timeout.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate grants on contention; 0 = master 0 always wins.
- TIMEOUT_CYCLES, 0: maximum BUSY cycles before abort; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF: value returned on m*_data_out when a transaction aborts.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- m0_read_enable / m1_read_enable  in  1  read request
- m0_write_enable / m1_write_enable  in  1  write request
- m0_mem_signed_read / m1_mem_signed_read  in  1  sign-extend read
- m0_mem_data_width / m1_mem_data_width  in  2  access width code, passed through unchanged
- m0_address / m1_address  in  32  byte address
- m0_data_in / m1_data_in  in  32  write data
- m0_data_out / m1_data_out  out  32  read data, valid while m*_mem_ready=1
- m0_mem_ready / m1_mem_ready  out  1  one-cycle completion pulse
- m0_bus_error / m1_bus_error  out  1  one-cycle pulse coincident with m*_mem_ready on timeout
- mmu_read_enable, mmu_write_enable, mmu_mem_signed_read  out  1  to mmu
- mmu_mem_data_width  out  2  to mmu
- mmu_address, mmu_data_in  out  32  to mmu
- mmu_data_out  in  32  from mmu
- mmu_mem_ready  in  1  from mmu

Behaviour:
- Reset: the FSM is sampled on posedge clk with reset_n=0.
  - State goes to IDLE; all outputs go to 0; last_grant=1, so master 0 wins the first contention; the timeout counter goes to 0.
  - Reset mid-transaction drops the mmu enables on the same edge. No ready pulse is generated.
- Request rule: master k requests when m{k}_read_enable or m{k}_write_enable is 1.
  - The master holds all of its request signals stable until it sees m{k}_mem_ready=1.
  - It changes or drops the request at the edge that samples the ready pulse.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - With no request, stay in IDLE and keep the mmu enables at 0.
  - With one request, grant that master.
  - With both requesting:
    - ROUND_ROBIN=1: grant master (1 - last_grant).
    - ROUND_ROBIN=0: grant master 0.
  - On grant:
    - Register the master's fields onto the mmu_* outputs.
    - Update last_grant and move to BUSY.
    - mmu_* is valid on the cycle after the request is first seen (1-cycle grant latency).
- Write precedence: if a master asserts write_enable and read_enable together, mmu_write_enable=1 and mmu_read_enable=0.
- BUSY:
  - The mmu_* outputs stay constant, and later changes on the master inputs are ignored.
  - On mmu_mem_ready=1:
    - Capture mmu_data_out into the granted master's data_out.
    - Clear the mmu enables, assert m{g}_mem_ready=1, and move to RESP.
  - Timeout (TIMEOUT_CYCLES>0):
    - The counter increments each BUSY cycle.
    - At count == TIMEOUT_CYCLES-1 with no mmu_mem_ready:
      - Load data_out=ERR_DATA and assert both m{g}_mem_ready=1 and m{g}_bus_error=1.
      - Clear the enables and move to RESP.
    - mmu_mem_ready on that same edge wins, with no error.
- RESP:
  - The ready (and error) pulse is high for exactly this cycle.
  - Next edge: clear the pulses, reset the counter, return to IDLE.
  - No arbitration happens in RESP, so back-to-back transactions from one master are spaced by 3 cycles plus the mmu latency.
- Non-granted master: its mem_ready and bus_error stay 0. Its data_out holds its last captured value.
- mmu_mem_ready while in IDLE or RESP is ignored.
- Fairness (ROUND_ROBIN=1): with both masters requesting continuously, grants strictly alternate 0,1,0,1.

Test Plan:
- Reset then idle: all outputs 0; no mmu enable for 10 cycles.
- Single read: m0 read at address 0x00000010; mmu returns 0x12345678 with mmu_mem_ready 2 cycles after enable.
  - mmu_read_enable high from cycle +1.
  - m0_data_out=0x12345678 with m0_mem_ready one-cycle pulse.
  - m1_mem_ready stays 0.
- Contention, round-robin: m0 and m1 both hold read requests for 4 transactions → mmu_address sequence m0,m1,m0,m1. With ROUND_ROBIN=0 → 4× m0 while m1 starves.
- Write with read also set: m1 write_enable=1, read_enable=1, data_in=0xA5A5A5A5, width=2'b10 → mmu_write_enable=1, mmu_read_enable=0, mmu_data_in=0xA5A5A5A5.
- Timeout: TIMEOUT_CYCLES=8, mmu never ready → after 8 BUSY cycles m0_mem_ready=1, m0_bus_error=1, data_out=0xDEADBEEF, then IDLE. Case with mmu_mem_ready arriving on the 8th cycle → no error.
- Reset mid-BUSY: reset_n=0 for 1 cycle → mmu enables 0 next cycle, no ready pulse, last_grant=1 (m0 wins next contention).
